hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/accumulate unit that owns the architectural Hi/Lo pair.
- It produces the 64-bit HiLo value that the ALU consumes for MFHI/MFLO/MADD/MSUB, and writes it back from the ALU operands.
- It sits beside the ALU in EX and stalls the pipeline through Busy while an iterative operation runs.

Parameters:
BITS_PER_CYCLE, 1, multiplier/divider bits retired per iteration; legal values 1, 2, 4; iteration count N = 32/BITS_PER_CYCLE

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
Start  input  1  request; sampled only when Busy=0
Op  input  3  000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 110 DIV, 111 DIVU
A  input  32  rs operand
B  input  32  rt operand
HiLo  output  64  {Hi,Lo} architectural register; feeds ALU HiLo input
Busy  output  1  high while iterative op in progress; pipeline stall
Done  output  1  one-cycle pulse when an op's result is visible on HiLo

Behaviour:
- Reset (Reset=0, async):
  - HiLo=0, Busy=0, Done=0, state=IDLE.
  - Internal accumulator, counter and operand registers cleared.
  - A reset mid-operation aborts the operation; HiLo reads 0, not the old value.
- States: IDLE, ITER, FINAL, DONE. Busy=1 exactly in ITER and FINAL.
- Acceptance:
  - Start is accepted in IDLE or DONE on rising edge E0.
  - Start while Busy=1 is ignored: no queueing, no error.
  - A new Start accepted in DONE state does not suppress that cycle's Done pulse.
- MTHI/MTLO:
  - At E0, Hi<=A (MTHI) or Lo<=A (MTLO); the other half is unchanged.
  - Next state DONE; Busy never asserts.
  - Done=1 for the cycle after E0.
- MULT/MULTU/MADD/MSUB:
  - E0 latches A, B, Op and the sign info; state ITER.
  - Signed ops (MULT/MADD/MSUB) multiply magnitudes, then negate the 64-bit product if the signs of A and B differ.
  - E1..EN: shift-add, BITS_PER_CYCLE bits per edge; counter counts N down to 0.
  - E(N+1), state FINAL, writes HiLo:
    - MULT/MULTU: HiLo<=product.
    - MADD: HiLo<=HiLo+product, mod 2^64.
    - MSUB: HiLo<=HiLo−product, mod 2^64.
  - HiLo is unchanged during ITER; intermediate values are never visible.
  - After E(N+1): state DONE, Done=1, Busy=0 for one cycle; next edge goes to IDLE unless Start is taken.
  - Latency from Start edge to HiLo update is N+1 edges (33 at default).
- MADD/MSUB read HiLo at the FINAL edge, not at E0. An intervening MTHI/MTLO cannot occur because Start is blocked while Busy.
- DIV/DIVU: see Optional Feature.
- Done never asserts in consecutive cycles except for back-to-back MTHI/MTLO.

Optional Feature:
Macro HILO_DIV_EN.
- Defined:
  - Op 110/111 run a restoring divider through ITER/FINAL with the same N+1 latency.
  - Lo<=quotient, Hi<=remainder.
  - DIV truncates toward zero; remainder takes the sign of A.
  - B=0: Hi<=A, Lo<=32'hFFFF_FFFF, same latency.
  - DIV 0x8000_0000 / 0xFFFF_FFFF: Lo<=0x8000_0000, Hi<=0.
- Undefined:
  - Op 110/111 behave as no-ops: HiLo unchanged, Busy stays 0, Done pulses the cycle after E0.
  - No divider logic is synthesised.

Test Plan:
- MULT A=0xFFFF_FFFF, B=2 -> Busy high 33 cycles; HiLo=0xFFFF_FFFF_FFFF_FFFE; Done one cycle. MULTU with the same operands -> HiLo=0x0000_0001_FFFF_FFFE.
- MTHI A=0x1234_5678, then MTLO A=0x9ABC_DEF0 on consecutive cycles -> Busy never high; HiLo=0x1234_5678_9ABC_DEF0; Done high two cycles.
- HiLo=0x10 via MTLO, then MADD A=3, B=4 -> HiLo=0x1C. Then MSUB A=0x1C, B=1 -> HiLo=0. Then MSUB A=1, B=1 -> HiLo=0xFFFF_FFFF_FFFF_FFFF.
- MULT running, Start pulsed with MTHI at cycle 5 -> ignored; final HiLo equals the product only. Repeat with BITS_PER_CYCLE=4 -> Busy high 9 cycles.
- Reset low at cycle 10 of MULT -> HiLo=0, Busy=0, Done=0 immediately. Then MULT A=7, B=6 -> HiLo=42.
- HILO_DIV_EN defined:
  - DIV A=−7, B=2 -> Lo=0xFFFF_FFFD, Hi=0xFFFF_FFFF.
  - DIVU A=7, B=0 -> Hi=7, Lo=0xFFFF_FFFF.
- HILO_DIV_EN undefined: DIV -> HiLo unchanged, Done pulses next cycle.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/accumulate unit owning the architectural Hi/Lo pair.
// Define HILO_DIV_EN to add the restoring divider for DIV/DIVU.
module hilo_muldiv_unit #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] HiLo,
    output logic        Busy,
    output logic        Done
);

    localparam int unsigned N = 32 / BITS_PER_CYCLE;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_DIV   = 3'b110;
    localparam logic [2:0] OP_DIVU  = 3'b111;

    typedef enum logic [1:0] {IDLE, ITER, FINAL, DONE} state_t;

    state_t      st, st_nxt;
    logic [5:0]  cnt;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [63:0] acc, mcand;
    logic [31:0] opb;
    logic [31:0] hi, lo;

    logic        accept, is_iter_op, signed_op;
    logic [31:0] a_mag, b_mag;
    logic [63:0] acc_step, mcand_step;
    logic [31:0] opb_step;
    logic [63:0] prod, res;

`ifdef HILO_DIV_EN
    logic        sa_q, dz_q;
    logic [31:0] a_q;
    logic [32:0] rem33;
    logic [31:0] quo_fix, rem_fix;
`endif

    assign HiLo   = {hi, lo};
    assign accept = Start && (st == IDLE || st == DONE);

    always_comb begin
        is_iter_op = ~Op[2];
        signed_op  = ~Op[2] && (Op != OP_MULTU);
`ifdef HILO_DIV_EN
        if (Op == OP_DIV || Op == OP_DIVU) is_iter_op = 1'b1;
        if (Op == OP_DIV) signed_op = 1'b1;
`endif
        a_mag = (signed_op && A[31]) ? -A : A;
        b_mag = (signed_op && B[31]) ? -B : B;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) st <= IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (st)
            IDLE, DONE: begin
                Done   = (st == DONE);
                st_nxt = Start ? (is_iter_op ? ITER : DONE) : IDLE;
            end
            ITER: begin
                Busy = 1'b1;
                if (cnt == 6'd1) st_nxt = FINAL;
            end
            FINAL: begin
                Busy   = 1'b1;
                st_nxt = DONE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    // One iteration: BITS_PER_CYCLE shift-add steps, or restoring-divide steps
    // with acc holding {remainder, dividend/quotient}.
    always_comb begin
        acc_step   = acc;
        mcand_step = mcand << BITS_PER_CYCLE;
        opb_step   = opb >> BITS_PER_CYCLE;
`ifdef HILO_DIV_EN
        rem33 = '0;
        if (op_q[2]) begin
            mcand_step = mcand;
            opb_step   = opb;
            for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
                rem33 = {acc_step[63:32], acc_step[31]};
                acc_step[31:0] = {acc_step[30:0], 1'b0};
                if (rem33 >= {1'b0, opb}) begin
                    rem33 = rem33 - {1'b0, opb};
                    acc_step[0] = 1'b1;
                end
                acc_step[63:32] = rem33[31:0];
            end
        end else
`endif
        begin
            for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
                if (opb[i]) acc_step = acc_step + (mcand << i);
            end
        end
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        res  = {hi, lo};
`ifdef HILO_DIV_EN
        quo_fix = neg_q ? -acc[31:0]  : acc[31:0];
        rem_fix = sa_q  ? -acc[63:32] : acc[63:32];
`endif
        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_MADD:           res = {hi, lo} + prod;
            OP_MSUB:           res = {hi, lo} - prod;
`ifdef HILO_DIV_EN
            OP_DIV, OP_DIVU:   res = dz_q ? {a_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
`endif
            default:           res = {hi, lo};
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            acc   <= '0;
            mcand <= '0;
            opb   <= '0;
            hi    <= '0;
            lo    <= '0;
`ifdef HILO_DIV_EN
            sa_q  <= 1'b0;
            dz_q  <= 1'b0;
            a_q   <= '0;
`endif
        end else if (accept) begin
            op_q  <= Op;
            neg_q <= signed_op && (A[31] ^ B[31]);
            cnt   <= 6'(N);
            acc   <= '0;
            mcand <= {32'b0, a_mag};
            opb   <= b_mag;
            if (Op == OP_MTHI) hi <= A;
            if (Op == OP_MTLO) lo <= A;
`ifdef HILO_DIV_EN
            sa_q <= signed_op && A[31];
            dz_q <= (B == '0);
            a_q  <= A;
            if (Op == OP_DIV || Op == OP_DIVU) acc <= {32'b0, a_mag};
`endif
        end else if (st == ITER) begin
            acc   <= acc_step;
            mcand <= mcand_step;
            opb   <= opb_step;
            cnt   <= cnt - 6'd1;
        end else if (st == FINAL) begin
            {hi, lo} <= res;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed table, hand sequences and a
// randomized run against an arithmetic reference model, on BITS_PER_CYCLE 1 and 4.
module tb_hilo_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [63:0] hilo1, hilo4;
    logic        busy1, busy4, done1, done4;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] mhilo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[$];

    always #5 Clk = ~Clk;

    hilo_muldiv_unit #(.BITS_PER_CYCLE(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiLo(hilo1), .Busy(busy1), .Done(done1)
    );

    hilo_muldiv_unit #(.BITS_PER_CYCLE(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiLo(hilo4), .Busy(busy4), .Done(done4)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_next(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] cur);
        longint sa, sb, sp;
        logic [63:0] up;
`ifdef HILO_DIV_EN
        longint sq, sr;
        logic [63:0] q64, r64;
`endif
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        up = {32'b0, a} * {32'b0, b};
        case (op)
            3'b000: return sp;
            3'b001: return up;
            3'b010: return cur + sp;
            3'b011: return cur - sp;
            3'b100: return {a, cur[31:0]};
            3'b101: return {cur[63:32], a};
`ifdef HILO_DIV_EN
            3'b110: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                q64 = sq;
                r64 = sr;
                return {r64[31:0], q64[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
`else
            default: return cur;
`endif
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] op, input int bpc);
        bit iter;
        iter = !op[2];
`ifdef HILO_DIV_EN
        if (op[2:1] == 2'b11) iter = 1'b1;
`endif
        return iter ? (32 / bpc + 1) : 0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op, optionally re-pulses Start (MTHI) while busy at loop cycle inj.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int inj);
        int bc1 = 0, bc4 = 0, dc1 = 0, dc4 = 0;
        bit s1 = 0, s4 = 0;
        logic [63:0] h1 = '0, h4 = '0;
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk);
        #1;
        Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
        for (int c = 0; c < 100 && !(s1 && s4); c++) begin
            @(negedge Clk);
            if (done1) begin
                dc1++;
                if (!s1) h1 = hilo1;
                s1 = 1;
            end else if (!s1 && busy1) bc1++;
            if (done4) begin
                dc4++;
                if (!s4) h4 = hilo4;
                s4 = 1;
            end else if (!s4 && busy4) bc4++;
            if (c == inj) begin
                Start = 1'b1; Op = 3'b100; A = 32'hDEAD_BEEF;
            end else begin
                Start = 1'b0;
            end
        end
        Start = 1'b0;
        @(negedge Clk);
        if (done1) dc1++;
        if (done4) dc4++;
        check_int({tag, " done_seen1"}, int'(s1), 1);
        check_int({tag, " done_seen4"}, int'(s4), 1);
        check64({tag, " hilo1"}, h1, exp);
        check64({tag, " hilo4"}, h4, exp);
        check_int({tag, " busy_cycles1"}, bc1, exp_busy(op, 1));
        check_int({tag, " busy_cycles4"}, bc4, exp_busy(op, 4));
        check_int({tag, " done_pulses1"}, dc1, 1);
        check_int({tag, " done_pulses4"}, dc4, 1);
        mhilo = exp;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dc1, dc4, bz;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        tbl.push_back('{3'b000, 32'hFFFF_FFFF, 32'd2,          64'hFFFF_FFFF_FFFF_FFFE});
        tbl.push_back('{3'b001, 32'hFFFF_FFFF, 32'd2,          64'h0000_0001_FFFF_FFFE});
        tbl.push_back('{3'b101, 32'h0000_0010, 32'd0,          64'h0000_0001_0000_0010});
        tbl.push_back('{3'b100, 32'd0,         32'd0,          64'h0000_0000_0000_0010});
        tbl.push_back('{3'b010, 32'd3,         32'd4,          64'h0000_0000_0000_001C});
        tbl.push_back('{3'b011, 32'h0000_001C, 32'd1,          64'h0000_0000_0000_0000});
        tbl.push_back('{3'b011, 32'd1,         32'd1,          64'hFFFF_FFFF_FFFF_FFFF});
`ifdef HILO_DIV_EN
        tbl.push_back('{3'b110, 32'd5,         32'd3,          64'h0000_0002_0000_0001});
`else
        tbl.push_back('{3'b110, 32'd5,         32'd3,          64'hFFFF_FFFF_FFFF_FFFF});
`endif
        tbl.push_back('{3'b000, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
        tbl.push_back('{3'b000, 32'd7,         32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6});
        tbl.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
        tbl.push_back('{3'b010, 32'hFFFF_FFFF, 32'd1,          64'hFFFF_FFFE_0000_0000});
`ifdef HILO_DIV_EN
        tbl.push_back('{3'b111, 32'd1,         32'd1,          64'h0000_0000_0000_0001});
        tbl.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFD});
        tbl.push_back('{3'b111, 32'd7,         32'd0,          64'h0000_0007_FFFF_FFFF});
        tbl.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000});
        tbl.push_back('{3'b110, 32'hFFFF_FFF9, 32'd0,          64'hFFFF_FFF9_FFFF_FFFF});
        tbl.push_back('{3'b110, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD});
`else
        tbl.push_back('{3'b111, 32'd1,         32'd1,          64'hFFFF_FFFE_0000_0000});
`endif

        // Reset state
        #2;
        check64("reset hilo1", hilo1, 64'd0);
        check64("reset hilo4", hilo4, 64'd0);
        check_int("reset busy1", int'(busy1), 0);
        check_int("reset done1", int'(done1), 0);
        check_int("reset busy4", int'(busy4), 0);
        check_int("reset done4", int'(done4), 0);
        @(negedge Clk);
        Reset = 1'b1;

        foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, -1);

        // Back-to-back MTHI then MTLO
        @(negedge Clk);
        Start = 1'b1; Op = 3'b100; A = 32'h1234_5678;
        @(posedge Clk);
        #1;
        Op = 3'b101; A = 32'h9ABC_DEF0;
        dc1 = 0; dc4 = 0; bz = 0;
        @(negedge Clk);
        dc1 += int'(done1); dc4 += int'(done4); bz += int'(busy1 | busy4);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            dc1 += int'(done1); dc4 += int'(done4); bz += int'(busy1 | busy4);
            if (k == 0) begin
                check64("mthi_mtlo hilo1", hilo1, 64'h1234_5678_9ABC_DEF0);
                check64("mthi_mtlo hilo4", hilo4, 64'h1234_5678_9ABC_DEF0);
            end
        end
        check_int("mthi_mtlo done_cycles1", dc1, 2);
        check_int("mthi_mtlo done_cycles4", dc4, 2);
        check_int("mthi_mtlo busy_cycles", bz, 0);
        mhilo = 64'h1234_5678_9ABC_DEF0;

        // Start while busy is ignored
        run_op("ignored_start", 3'b000, 32'd5, 32'd9, 64'd45, 4);

        // Asynchronous reset in the middle of a MULT
        @(negedge Clk);
        Start = 1'b1; Op = 3'b000; A = 32'h0000_FFFF; B = 32'h0000_1234;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (10) @(negedge Clk);
        Reset = 1'b0;
        #1;
        check64("midreset hilo1", hilo1, 64'd0);
        check64("midreset hilo4", hilo4, 64'd0);
        check_int("midreset busy1", int'(busy1), 0);
        check_int("midreset busy4", int'(busy4), 0);
        check_int("midreset done1", int'(done1), 0);
        check_int("midreset done4", int'(done4), 0);
        @(negedge Clk);
        Reset = 1'b1;
        mhilo = '0;
        run_op("after_reset", 3'b000, 32'd7, 32'd6, 64'd42, -1);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, ref_next(rop, ra, rb, mhilo), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
